ccff_chain_loader: RTL and testbench

- Drives a configuration chain (ccff_head through ccff_tail) of CB/SB/grid memories.
- Accepts bitstream words over a valid/ready stream and serializes them onto ccff_head, one bit per gated prog_clk edge.
- Optionally pre-shifts a known pattern so that chain integrity can be checked on ccff_tail while the real bitstream loads.
- Sits at the fabric top, ahead of the first tile's ccff_head; ccff_tail of the last tile returns to it.

---
 rtl/ccff_chain_loader_pkg.sv | 21 ++
 rtl/ccff_chain_loader_if.sv | 11 +
 rtl/ccff_chain_loader_serializer.sv | 54 +++++
 rtl/ccff_chain_loader.sv | 131 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PATTERN = 2'd1,
        ST_LOAD    = 2'd2,
        ST_DONE    = 2'd3
    } ccff_state_t;

    // Width of a counter that must reach chain_len inclusive.
    function automatic int ccff_cnt_w(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    // Integrity pattern: 1,0,1,0... indexed by shift number.
    function automatic logic pat_bit(input logic [31:0] idx);
        return ~idx[0];
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into the loader (valid/ready).
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input  cfg_ready);
    modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader_serializer.sv
// One-word buffer that feeds the chain head LSB first.
// When a word runs out the bit index stays on its last bit, so head_bit
// keeps the last shifted value while the chain is stalled.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic               prog_clk,
    input  logic               prog_reset,
    ccff_chain_loader_if.slave cfg,
    input  logic               intake_en,
    input  logic               shift,
    input  logic               flush,
    output logic               accept,
    output logic               empty,
    output logic               head_bit
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] word_buf;
    logic [IDX_W-1:0]  bit_idx;
    logic              full;
    logic              last_bit_out;

    assign last_bit_out  = full && shift && (bit_idx == LAST_IDX);
    assign cfg.cfg_ready = intake_en && (!full || last_bit_out);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign empty         = !full;
    assign head_bit      = word_buf[bit_idx];

    // Buffer fill on handshake, bit index advance on each accepted shift.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            word_buf <= '0;
            bit_idx  <= '0;
            full     <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (accept) begin
            word_buf <= cfg.cfg_data;
            bit_idx  <= '0;
            full     <= 1'b1;
        end else if (full && shift) begin
            if (bit_idx == LAST_IDX) begin
                full <= 1'b0;
            end else begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: optional 1010 pre-shift, then bitstream load
// with tail-vs-pattern integrity compare.
//
// state   | meaning
// IDLE    | waiting for start
// PATTERN | shifting CHAIN_LEN pattern bits into the chain
// LOAD    | shifting bitstream bits, stalls when no word is buffered
// DONE    | chain loaded; start begins a new load
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8,
    parameter bit CHECK_EN  = 1'b1
) (
    input  logic                              prog_clk,
    input  logic                              prog_reset,
    input  logic                              start,
    ccff_chain_loader_if.slave                cfg,
    output logic                              ccff_head,
    input  logic                              ccff_tail,
    output logic                              ccff_shift_en,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [ccff_cnt_w(CHAIN_LEN)-1:0]  bit_count
);
    localparam int CNT_W   = ccff_cnt_w(CHAIN_LEN);
    localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WCNT_W  = $clog2(N_WORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] WORDS_NEED = WCNT_W'(N_WORDS);

    ccff_state_t       state, state_nxt;
    logic [WCNT_W-1:0] words_taken;
    logic              start_ok;
    logic              in_load;
    logic              last_shift;
    logic              ser_enable;
    logic              ser_accept;
    logic              ser_empty;
    logic              ser_head;

    assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign in_load    = (state == ST_LOAD);
    assign ser_enable = in_load && (words_taken < WORDS_NEED);
    assign last_shift = ccff_shift_en && (bit_count == LAST_BIT);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .cfg        (cfg),
        .intake_en  (ser_enable),
        .shift      (in_load && !ser_empty),
        .flush      (in_load && last_shift),
        .accept     (ser_accept),
        .empty      (ser_empty),
        .head_bit   (ser_head)
    );

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = CHECK_EN ? ST_PATTERN : ST_LOAD;
            ST_PATTERN:       if (last_shift) state_nxt = ST_LOAD;
            ST_LOAD:          if (last_shift) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Per-state outputs; shift enable gates the chain clock.
    always_comb begin
        ccff_shift_en = 1'b0;
        ccff_head     = ser_head;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            ST_PATTERN: begin
                ccff_shift_en = 1'b1;
                ccff_head     = pat_bit(32'(bit_count));
                busy          = 1'b1;
            end
            ST_LOAD: begin
                ccff_shift_en = !ser_empty;
                busy          = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Shift counter, sticky integrity flag and accepted-word count.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            bit_count   <= '0;
            error       <= 1'b0;
            words_taken <= '0;
        end else if (start_ok) begin
            bit_count   <= '0;
            error       <= 1'b0;
            words_taken <= '0;
        end else begin
            if (ccff_shift_en) begin
                if ((state == ST_PATTERN) && last_shift) begin
                    bit_count <= '0;
                end else begin
                    bit_count <= bit_count + CNT_W'(1);
                end
                if (CHECK_EN && in_load && (ccff_tail != pat_bit(32'(bit_count)))) begin
                    error <= 1'b1;
                end
            end
            if (ser_accept) begin
                words_taken <= words_taken + WCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: three loader configurations, each driving a behavioural chain.
module tb_ccff_chain_loader;

    logic prog_clk   = 1'b0;
    logic prog_reset = 1'b1;
    always #5 prog_clk = ~prog_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // A: CHAIN_LEN=8, WORD_W=8, CHECK_EN=0
    logic       a_start = 1'b0;
    logic       a_head, a_tail, a_shen, a_busy, a_done, a_err;
    logic [3:0] a_cnt;
    logic [7:0] a_chain = '0;
    ccff_chain_loader_if #(.WORD_W(8)) ifa ();
    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .CHECK_EN(1'b0)) dut_a (
        .prog_clk (prog_clk), .prog_reset (prog_reset), .start (a_start), .cfg (ifa),
        .ccff_head (a_head), .ccff_tail (a_tail), .ccff_shift_en (a_shen),
        .busy (a_busy), .done (a_done), .error (a_err), .bit_count (a_cnt)
    );
    always @(posedge prog_clk) if (a_shen) a_chain <= {a_head, a_chain[7:1]};
    assign a_tail = a_chain[0];

    // B: CHAIN_LEN=8, WORD_W=8, CHECK_EN=1, chain flop 3 optionally stuck at 0
    logic       b_start = 1'b0;
    logic       b_stuck = 1'b0;
    logic       b_head, b_tail, b_shen, b_busy, b_done, b_err;
    logic [3:0] b_cnt;
    logic [7:0] b_chain = '0;
    ccff_chain_loader_if #(.WORD_W(8)) ifb ();
    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .CHECK_EN(1'b1)) dut_b (
        .prog_clk (prog_clk), .prog_reset (prog_reset), .start (b_start), .cfg (ifb),
        .ccff_head (b_head), .ccff_tail (b_tail), .ccff_shift_en (b_shen),
        .busy (b_busy), .done (b_done), .error (b_err), .bit_count (b_cnt)
    );
    always @(posedge prog_clk)
        if (b_shen) b_chain <= {b_head, b_chain[7:5], b_chain[4] & ~b_stuck, b_chain[3:1]};
    assign b_tail = b_chain[0];

    // C: CHAIN_LEN=11, WORD_W=4, CHECK_EN=1
    logic        c_start = 1'b0;
    logic        c_head, c_tail, c_shen, c_busy, c_done, c_err;
    logic [3:0]  c_cnt;
    logic [10:0] c_chain = '0;
    ccff_chain_loader_if #(.WORD_W(4)) ifc ();
    ccff_chain_loader #(.CHAIN_LEN(11), .WORD_W(4), .CHECK_EN(1'b1)) dut_c (
        .prog_clk (prog_clk), .prog_reset (prog_reset), .start (c_start), .cfg (ifc),
        .ccff_head (c_head), .ccff_tail (c_tail), .ccff_shift_en (c_shen),
        .busy (c_busy), .done (c_done), .error (c_err), .bit_count (c_cnt)
    );
    always @(posedge prog_clk) if (c_shen) c_chain <= {c_head, c_chain[10:1]};
    assign c_tail = c_chain[0];

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] w8;
        ifa.cfg_valid = 1'b0; ifa.cfg_data = '0;
        ifb.cfg_valid = 1'b0; ifb.cfg_data = '0;
        ifc.cfg_valid = 1'b0; ifc.cfg_data = '0;
        tick(); tick();
        chk("rst_ready", ifa.cfg_ready, 0);
        chk("rst_head",  a_head, 0);
        chk("rst_shen",  a_shen, 0);
        chk("rst_busy",  a_busy, 0);
        chk("rst_done",  a_done, 0);
        chk("rst_err",   a_err, 0);
        chk("rst_cnt",   a_cnt, 0);
        prog_reset = 1'b0;
        tick();

        // A: load 0xA5, no pattern phase
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk("a5_busy", a_busy, 1);
        chk("a5_ready_empty", ifa.cfg_ready, 1);
        chk("a5_shen_stall", a_shen, 0);
        ifa.cfg_valid = 1'b1; ifa.cfg_data = 8'hA5; tick();
        w8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("a5_head", a_head, w8[i]);
            chk("a5_shen", a_shen, 1);
            chk("a5_cnt", a_cnt, i);
            chk("a5_ready_full", ifa.cfg_ready, 0);
            tick();
        end
        chk("a5_done", a_done, 1);
        chk("a5_busy_end", a_busy, 0);
        chk("a5_shen_end", a_shen, 0);
        chk("a5_cnt_end", a_cnt, 8);
        chk("a5_ready_done", ifa.cfg_ready, 0);
        chk("a5_chain", a_chain, 8'hA5);
        ifa.cfg_valid = 1'b0;

        // A: start pulse mid-LOAD is ignored
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk("ign_cnt_clr", a_cnt, 0);
        ifa.cfg_valid = 1'b1; ifa.cfg_data = 8'h3C; tick(); ifa.cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ign_cnt", a_cnt, i);
            chk("ign_shen", a_shen, 1);
            chk("ign_done", a_done, 0);
            a_start = (i == 3);
            tick();
        end
        a_start = 1'b0;
        chk("ign_done_end", a_done, 1);
        chk("ign_cnt_end", a_cnt, 8);
        chk("ign_chain", a_chain, 8'h3C);

        // B: pattern pre-shift with a healthy chain
        b_stuck = 1'b0;
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("bp_shen", b_shen, 1);
            chk("bp_head", b_head, (i % 2) == 0);
            chk("bp_ready", ifb.cfg_ready, 0);
            tick();
        end
        chk("bp_load_cnt", b_cnt, 0);
        chk("bp_load_busy", b_busy, 1);
        chk("bp_load_ready", ifb.cfg_ready, 1);
        ifb.cfg_valid = 1'b1; ifb.cfg_data = 8'h96; tick(); ifb.cfg_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk("bl_tail", b_tail, (j % 2) == 0);
            chk("bl_err", b_err, 0);
            tick();
        end
        chk("bl_done", b_done, 1);
        chk("bl_err_end", b_err, 0);
        chk("bl_chain", b_chain, 8'h96);

        // B: flop 3 stuck at 0 flags an integrity error
        b_stuck = 1'b1;
        b_start = 1'b1; tick(); b_start = 1'b0;
        repeat (8) tick();
        ifb.cfg_valid = 1'b1; ifb.cfg_data = 8'h96; tick(); ifb.cfg_valid = 1'b0;
        repeat (8) tick();
        chk("bs_done", b_done, 1);
        chk("bs_err", b_err, 1);
        repeat (3) tick();
        chk("bs_err_sticky", b_err, 1);
        chk("bs_done_hold", b_done, 1);
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("bs_err_clr", b_err, 0);
        chk("bs_cnt_clr", b_cnt, 0);
        chk("bs_busy", b_busy, 1);

        // C: 11-bit chain, 4-bit words, gaps between words
        c_start = 1'b1; tick(); c_start = 1'b0;
        repeat (11) tick();
        chk("c_load_cnt", c_cnt, 0);
        chk("c_ready0", ifc.cfg_ready, 1);
        ifc.cfg_valid = 1'b1; ifc.cfg_data = 4'hF; tick(); ifc.cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("c_w0_shen", c_shen, 1);
            chk("c_w0_head", c_head, 1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("c_gap0_shen", c_shen, 0);
            chk("c_gap0_head", c_head, 1);
            chk("c_gap0_cnt", c_cnt, 4);
            chk("c_gap0_ready", ifc.cfg_ready, 1);
            tick();
        end
        ifc.cfg_valid = 1'b1; ifc.cfg_data = 4'h0; tick(); ifc.cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("c_w1_shen", c_shen, 1);
            chk("c_w1_head", c_head, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("c_gap1_shen", c_shen, 0);
            chk("c_gap1_head", c_head, 0);
            chk("c_gap1_cnt", c_cnt, 8);
            tick();
        end
        ifc.cfg_valid = 1'b1; ifc.cfg_data = 4'hF; tick(); ifc.cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("c_w2_shen", c_shen, 1);
            chk("c_w2_head", c_head, 1);
            tick();
        end
        chk("c_done", c_done, 1);
        chk("c_cnt_end", c_cnt, 11);
        chk("c_err", c_err, 0);
        chk("c_shen_end", c_shen, 0);
        chk("c_ready_end", ifc.cfg_ready, 0);
        chk("c_chain", c_chain, 11'b111_0000_1111);

        // A: reset in the middle of a load, then a full reload
        a_start = 1'b1; tick(); a_start = 1'b0;
        ifa.cfg_valid = 1'b1; ifa.cfg_data = 8'hFF; tick(); ifa.cfg_valid = 1'b0;
        repeat (5) tick();
        chk("mr_cnt5", a_cnt, 5);
        chk("mr_shen5", a_shen, 1);
        prog_reset = 1'b1; tick();
        chk("mr_ready", ifa.cfg_ready, 0);
        chk("mr_head", a_head, 0);
        chk("mr_shen", a_shen, 0);
        chk("mr_busy", a_busy, 0);
        chk("mr_done", a_done, 0);
        chk("mr_err", a_err, 0);
        chk("mr_cnt", a_cnt, 0);
        prog_reset = 1'b0; tick();
        a_start = 1'b1; tick(); a_start = 1'b0;
        ifa.cfg_valid = 1'b1; ifa.cfg_data = 8'h5A; tick(); ifa.cfg_valid = 1'b0;
        repeat (8) tick();
        chk("mr_reload_done", a_done, 1);
        chk("mr_reload_chain", a_chain, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
